// File: rtl/fwd_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl_if
// Bundles the ID-stage hazard inputs and the controller's stall / forwarding
// outputs between the core pipeline and fwd_hazard_ctrl.
//   master : core pipeline side (drives ID fields, hold, flush)
//   slave  : hazard controller side (drives stall_id, ex_fwd, id_bypass,
//            stall_cnt)
// Signals:
//   id_valid, id_src[NUM_SRC*REG_AW], id_src_used[NUM_SRC], id_rd, id_rw,
//   id_is_load, hold, flush           -> controller
//   stall_id, ex_fwd[2*NUM_SRC], id_bypass[NUM_SRC], stall_cnt[16]
//                                     <- controller
// ---------------------------------------------------------------------------
interface fwd_hazard_ctrl_if #(
    parameter int REG_AW  = 4,
    parameter int NUM_SRC = 2
);
    logic                        id_valid;
    logic [NUM_SRC*REG_AW-1:0]   id_src;
    logic [NUM_SRC-1:0]          id_src_used;
    logic [REG_AW-1:0]           id_rd;
    logic                        id_rw;
    logic                        id_is_load;
    logic                        hold;
    logic                        flush;
    logic                        stall_id;
    logic [2*NUM_SRC-1:0]        ex_fwd;
    logic [NUM_SRC-1:0]          id_bypass;
    logic [15:0]                 stall_cnt;

    modport master (
        output id_valid, id_src, id_src_used, id_rd, id_rw, id_is_load, hold, flush,
        input  stall_id, ex_fwd, id_bypass, stall_cnt
    );

    modport slave (
        input  id_valid, id_src, id_src_used, id_rd, id_rw, id_is_load, hold, flush,
        output stall_id, ex_fwd, id_bypass, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
// Forwarding and load-use hazard controller for the 5-stage core. Keeps a
// shadow copy of the ID/EX, EX/MEM and MEM/WB register tags and derives:
//   - per-operand EX forwarding selects (00 regfile, 10 EX/MEM, 01 MEM/WB)
//   - a one-cycle load-use stall for ID
//   - optional WB-to-ID bypass (compile with FWD_WB_BYPASS_EN defined)
//   - a saturating 16-bit count of load-use stall cycles
// Ports:
//   clk    core clock
//   rst_n  asynchronous active-low reset
//   bus    fwd_hazard_ctrl_if.slave (ID fields, hold, flush in;
//          stall_id, ex_fwd, id_bypass, stall_cnt out)
// Parameters: REG_AW (tag width), NUM_SRC (operands, 1..4),
//             ZERO_REG (1: r0 never forwards and never stalls)
// Optional feature macro: FWD_WB_BYPASS_EN
// ---------------------------------------------------------------------------

// Per-operand comparator slice: one instance per source operand.
module fwd_hazard_lane #(
    parameter int REG_AW   = 4,
    parameter int ZERO_REG = 1
) (
    // ID-side operand
    input  logic [REG_AW-1:0] id_src,
    input  logic              id_used,
    // same operand as captured in S_EX
    input  logic [REG_AW-1:0] ex_src,
    input  logic              ex_used,
    // shadow stage state
    input  logic              ex_vld,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_rw,
    input  logic              ex_ld,
    input  logic              mem_vld,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_rw,
    input  logic              mem_ld,
    input  logic              wb_vld,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_rw,
    // results
    output logic              lu_hit,
    output logic [1:0]        fwd,
    output logic              byp
);
    // Stage entry "writes r": live, writes, same tag, and not the zero register.
    function automatic logic writes(input logic v, input logic rw,
                                    input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] r);
        return v & rw & (rd == r) & !((ZERO_REG != 0) && (r == '0));
    endfunction

    logic mem_m, wb_m;

    assign lu_hit = id_used & ex_ld & writes(ex_vld, ex_rw, ex_rd, id_src);

    // A load still in EX/MEM has no data yet; the stall ensures the consumer
    // only meets it once it sits in MEM/WB.
    assign mem_m = writes(mem_vld, mem_rw, mem_rd, ex_src) & !mem_ld;
    assign wb_m  = writes(wb_vld, wb_rw, wb_rd, ex_src);

    always_comb begin
        fwd = 2'b00;
        if (ex_vld & ex_used) begin
            if (mem_m)     fwd = 2'b10;   // youngest producer wins
            else if (wb_m) fwd = 2'b01;
        end
    end

`ifdef FWD_WB_BYPASS_EN
    assign byp = id_used & writes(wb_vld, wb_rw, wb_rd, id_src);
`else
    assign byp = 1'b0;
`endif
endmodule

module fwd_hazard_ctrl #(
    parameter int REG_AW   = 4,
    parameter int NUM_SRC  = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_hazard_ctrl_if.slave  bus
);
    localparam int STAGES = 2;   // vld_pipe[0]=S_EX, [1]=S_MEM, [2]=S_WB

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              rw;
        logic              ld;
    } stg_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              rw;
    } wb_t;

    logic [STAGES:0]                  vld_pipe;
    stg_t                             ex_q, mem_q;
    wb_t                              wb_q;
    logic [NUM_SRC-1:0][REG_AW-1:0]   ex_src_q;
    logic [NUM_SRC-1:0]               ex_used_q;
    logic [15:0]                      cnt_q;

    logic [NUM_SRC-1:0][REG_AW-1:0]   id_src;
    logic [NUM_SRC-1:0]               lu_hit;
    logic [NUM_SRC-1:0][1:0]          fwd;
    logic [NUM_SRC-1:0]               byp;
    logic                             stall;

    assign id_src = bus.id_src;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_lane
        fwd_hazard_lane #(
            .REG_AW   (REG_AW),
            .ZERO_REG (ZERO_REG)
        ) u_lane (
            .id_src  (id_src[k]),
            .id_used (bus.id_src_used[k]),
            .ex_src  (ex_src_q[k]),
            .ex_used (ex_used_q[k]),
            .ex_vld  (vld_pipe[0]),
            .ex_rd   (ex_q.rd),
            .ex_rw   (ex_q.rw),
            .ex_ld   (ex_q.ld),
            .mem_vld (vld_pipe[1]),
            .mem_rd  (mem_q.rd),
            .mem_rw  (mem_q.rw),
            .mem_ld  (mem_q.ld),
            .wb_vld  (vld_pipe[2]),
            .wb_rd   (wb_q.rd),
            .wb_rw   (wb_q.rw),
            .lu_hit  (lu_hit[k]),
            .fwd     (fwd[k]),
            .byp     (byp[k])
        );
    end

    // Not masked by hold: the stall must stay asserted across a freeze so the
    // consumer is not released early. flush wins since ID becomes a bubble.
    assign stall = bus.id_valid & !bus.flush & (|lu_hit);

    assign bus.stall_id  = stall;
    assign bus.ex_fwd    = fwd;
    assign bus.id_bypass = byp & {NUM_SRC{bus.id_valid}};
    assign bus.stall_cnt = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            ex_src_q  <= '0;
            ex_used_q <= '0;
            cnt_q     <= '0;
        end else if (!bus.hold) begin
            vld_pipe  <= {vld_pipe[STAGES-1:0], bus.id_valid & !stall & !bus.flush};
            wb_q      <= '{rd: mem_q.rd, rw: mem_q.rw};
            mem_q     <= ex_q;
            ex_q      <= '{rd: bus.id_rd, rw: bus.id_rw, ld: bus.id_is_load};
            ex_src_q  <= id_src;
            ex_used_q <= bus.id_src_used;
            if (stall && cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
// Directed scenarios for reset, ALU chains, load-use, double match, r0,
// hold/flush and WB bypass, followed by a randomized run. Every cycle the
// outputs are compared against an instruction-level reference model that
// tracks the three in-flight instructions after ID.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;
    localparam int REG_AW  = 4;
    localparam int NUM_SRC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fwd_hazard_ctrl_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC)) bus ();

    fwd_hazard_ctrl #(
        .REG_AW   (REG_AW),
        .NUM_SRC  (NUM_SRC),
        .ZERO_REG (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---- reference model: instructions in EX(0), MEM(1), WB(2) ----
    bit m_v[3];
    int m_rd[3];
    bit m_rw[3];
    bit m_ld[3];
    int m_src[NUM_SRC];
    bit m_used[NUM_SRC];
    int m_cnt;

    // current ID-stage inputs
    bit in_v, in_rw, in_ld, in_hold, in_flush;
    int in_src[NUM_SRC];
    bit in_used[NUM_SRC];
    int in_rd;

    function automatic void m_reset();
        for (int i = 0; i < 3; i++) m_v[i] = 0;
        m_cnt = 0;
    endfunction

    function automatic bit m_writes(int i, int r);
        return m_v[i] && m_rw[i] && m_rd[i] == r && r != 0;
    endfunction

    function automatic bit m_stall();
        bit s = 0;
        if (!in_v || in_flush) return 0;
        for (int k = 0; k < NUM_SRC; k++)
            if (in_used[k] && m_ld[0] && m_writes(0, in_src[k])) s = 1;
        return s;
    endfunction

    function automatic int m_fwd(int k);
        if (!(m_v[0] && m_used[k])) return 0;
        if (m_writes(1, m_src[k]) && !m_ld[1]) return 2;
        if (m_writes(2, m_src[k])) return 1;
        return 0;
    endfunction

    function automatic bit m_byp(int k);
`ifdef FWD_WB_BYPASS_EN
        return in_v && in_used[k] && m_writes(2, in_src[k]);
`else
        return 0;
`endif
    endfunction

    task automatic drive(input bit v, input int s0, input int s1, input bit [1:0] used,
                         input int rd, input bit rw, input bit ld, input bit hold, input bit flush);
        in_v = v; in_src[0] = s0; in_src[1] = s1; in_used[0] = used[0]; in_used[1] = used[1];
        in_rd = rd; in_rw = rw; in_ld = ld; in_hold = hold; in_flush = flush;
        bus.id_valid    = v;
        bus.id_src      = {4'(s1), 4'(s0)};
        bus.id_src_used = used;
        bus.id_rd       = 4'(rd);
        bus.id_rw       = rw;
        bus.id_is_load  = ld;
        bus.hold        = hold;
        bus.flush       = flush;
        #1;
    endtask

    task automatic nop();
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    endtask
    task automatic alu(input int rd, input int s0, input int s1, input bit [1:0] used);
        drive(1, s0, s1, used, rd, 1, 0, 0, 0);
    endtask
    task automatic lw(input int rd);
        drive(1, 0, 0, 2'b00, rd, 1, 1, 0, 0);
    endtask

    // Compare this cycle against the model, then advance model with the edge.
    task automatic tick();
        bit st;
        st = m_stall();
        chk("stall_id", 32'(bus.stall_id), 32'(st));
        for (int k = 0; k < NUM_SRC; k++) begin
            chk("ex_fwd", 32'(bus.ex_fwd[2*k +: 2]), 32'(m_fwd(k)));
            chk("id_bypass", 32'(bus.id_bypass[k]), 32'(m_byp(k)));
        end
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
        @(posedge clk);
        if (!rst_n) begin
            m_reset();
        end else if (!in_hold) begin
            for (int i = 2; i > 0; i--) begin
                m_v[i] = m_v[i-1]; m_rd[i] = m_rd[i-1];
                m_rw[i] = m_rw[i-1]; m_ld[i] = m_ld[i-1];
            end
            m_v[0] = in_v && !st && !in_flush;
            m_rd[0] = in_rd; m_rw[0] = in_rw; m_ld[0] = in_ld;
            for (int k = 0; k < NUM_SRC; k++) begin
                m_src[k] = in_src[k]; m_used[k] = in_used[k];
            end
            if (st && m_cnt < 65535) m_cnt++;
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        for (int i = 0; i < 3; i++) begin m_rd[i] = 0; m_rw[i] = 0; m_ld[i] = 0; end
        for (int k = 0; k < NUM_SRC; k++) begin m_src[k] = 0; m_used[k] = 0; end
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_stall", 32'(bus.stall_id), 0);
        chk("rst_fwd", 32'(bus.ex_fwd), 0);
        chk("rst_byp", 32'(bus.id_bypass), 0);
        chk("rst_cnt", 32'(bus.stall_cnt), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // back-to-back ALU dependency -> EX/MEM
        alu(3, 1, 2, 2'b11); tick();
        alu(8, 3, 0, 2'b01); tick();
        nop(); chk("alu_fwd10", 32'(bus.ex_fwd[1:0]), 32'h2); tick();

        // one independent instruction between -> MEM/WB
        alu(4, 1, 2, 2'b11); tick();
        nop(); tick();
        alu(9, 4, 0, 2'b01); tick();
        nop(); chk("alu_fwd01", 32'(bus.ex_fwd[1:0]), 32'h1); tick();

        // load-use: one stall cycle then MEM/WB forward on both operands
        lw(5); tick();
        alu(6, 5, 5, 2'b11);
        chk("lu_stall", 32'(bus.stall_id), 1);
        chk("lu_cnt0", 32'(bus.stall_cnt), 0);
        tick();
        chk("lu_stall_drop", 32'(bus.stall_id), 0);
        chk("lu_cnt1", 32'(bus.stall_cnt), 1);
        tick();
        nop(); chk("lu_fwd", 32'(bus.ex_fwd), 32'h5); tick();

        // r2 in both MEM and WB: youngest wins
        alu(2, 1, 1, 2'b01); tick();
        alu(2, 1, 1, 2'b01); tick();
        alu(10, 2, 0, 2'b01); tick();
        nop(); chk("dbl_fwd10", 32'(bus.ex_fwd[1:0]), 32'h2); tick();

        // r0 never forwards, never stalls
        alu(0, 1, 1, 2'b01); tick();
        alu(11, 0, 0, 2'b01); tick();
        nop(); chk("r0_fwd", 32'(bus.ex_fwd[1:0]), 0); tick();
        lw(0); tick();
        alu(11, 0, 0, 2'b01); chk("r0_stall", 32'(bus.stall_id), 0); tick();

        // hold during a load-use stall
        lw(5); tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 5, 0, 2'b01, 6, 1, 0, 1, 0);
            chk("hold_stall", 32'(bus.stall_id), 1);
            chk("hold_cnt", 32'(bus.stall_cnt), 1);
            tick();
        end
        alu(6, 5, 0, 2'b01); chk("hold_rel_stall", 32'(bus.stall_id), 1); tick();
        nop(); chk("hold_cnt_after", 32'(bus.stall_cnt), 2); tick();

        // flush masks the stall and inserts a bubble
        lw(5); tick();
        drive(1, 5, 0, 2'b01, 6, 1, 0, 0, 1);
        chk("flush_stall", 32'(bus.stall_id), 0);
        tick();
        nop();
        chk("flush_bubble_fwd", 32'(bus.ex_fwd), 0);
        chk("flush_cnt", 32'(bus.stall_cnt), 2);
        tick();

        // WB-to-ID bypass on src1
        alu(7, 1, 1, 2'b00); tick();
        nop(); tick();
        nop(); tick();
        alu(12, 0, 7, 2'b10);
`ifdef FWD_WB_BYPASS_EN
        chk("wb_bypass", 32'(bus.id_bypass), 32'h2);
`else
        chk("wb_bypass", 32'(bus.id_bypass), 32'h0);
`endif
        tick();

        // reset in the middle of a stall
        lw(5); tick();
        alu(6, 5, 5, 2'b11); chk("mid_stall", 32'(bus.stall_id), 1);
        rst_n = 1'b0; m_reset(); #1;
        chk("mid_rst_stall", 32'(bus.stall_id), 0);
        chk("mid_rst_fwd", 32'(bus.ex_fwd), 0);
        chk("mid_rst_cnt", 32'(bus.stall_cnt), 0);
        tick();
        nop();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_cnt", 32'(bus.stall_cnt), 0);
            chk("post_rst_stall", 32'(bus.stall_id), 0);
        end

        // randomized run
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 7) != 0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0; m_reset(); #1;
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Parametrised forwarding and load-use hazard controller for the 5-stage core. It tracks destination and source register tags for the ID/EX, EX/MEM and MEM/WB stages in its own shadow pipeline. From that state it produces per-operand EX forwarding selects and a one-cycle load-use stall for ID. It replaces the per-stage tag wiring into the datapath and scales with register-file size and operand count.

## Interface
Parameters:
- REG_AW, 4, register-tag width (register file has 2^REG_AW entries)
- NUM_SRC, 2, source operands per instruction (1..4)
- ZERO_REG, 1, when 1 register 0 is hardwired zero: never forwarded, never causes a stall

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_src  in  NUM_SRC*REG_AW  source tags; operand k is bits [k*REG_AW +: REG_AW]
- id_src_used  in  NUM_SRC  operand k is actually read
- id_rd  in  REG_AW  destination tag
- id_rw  in  1  instruction writes id_rd
- id_is_load  in  1  instruction is a load
- hold  in  1  external pipeline freeze (e.g. memory wait); shadow pipeline does not advance
- flush  in  1  branch redirect; ID instruction becomes a bubble into ID/EX
- stall_id  out  1  load-use stall request to PC/IF-ID
- ex_fwd  out  2*NUM_SRC  per-operand EX mux select at [2k +: 2]: 00 register file, 10 EX/MEM, 01 MEM/WB
- id_bypass  out  NUM_SRC  WB-to-ID register-file bypass (FWD_WB_BYPASS_EN only; otherwise tied 0)
- stall_cnt  out  16  saturating count of load-use stall cycles

## Operation
- Shadow stages S_EX (ID/EX), S_MEM (EX/MEM), S_WB (MEM/WB). Each stage holds valid, rd, rw, load, and for S_EX also the src and used tags.
- A stage entry is "writing r" when valid & rw & rd==r & !(ZERO_REG & r==0).
- Advance on each edge with !hold:
  - S_WB <= S_MEM.
  - S_MEM <= S_EX.
  - S_EX <= ID fields, or a bubble (valid=0) if stall_id | flush | !id_valid.
- hold=1: all stages and stall_cnt keep their values.
- hold has priority over flush and stall_id.
- stall_id = id_valid & S_EX writing id_src[k] & S_EX.load & id_src_used[k], for any k.
  - stall_id is not masked by hold.
  - stall_id is masked by flush: flush forces stall_id=0.
- ex_fwd[k], evaluated for the S_EX entry with S_EX.valid & used[k]:
  - 10 if S_MEM writing src[k] & !S_MEM.load.
  - Else 01 if S_WB writing src[k].
  - Else 00.
  - The younger stage (S_MEM) wins when both stages match.
- A load in S_MEM never selects 10. The stall guarantees the consumer reaches EX only when the load is in S_WB, where it selects 01.
- stall_cnt increments by 1 on edges where stall_id & !hold. It saturates at 16'hFFFF.

## Timing
- Reset (rst_n low, asynchronous) clears all stage valid bits and stall_cnt.
  - While reset is asserted and after it: stall_id=0, ex_fwd=0, id_bypass=0, stall_cnt=0.
- Reset mid-stall drops stall_id immediately, without waiting for a clock edge.
- ex_fwd depends only on registered state: it is valid from clock-to-q and stable for the whole cycle.
- stall_id is combinational from the ID inputs and S_EX.
- Load-use penalty is exactly 1 cycle:
  - Cycle n: stall_id=1.
  - Edge n: a bubble enters S_EX and the load moves to S_MEM.
  - Cycle n+1: stall_id=0.
  - Cycle n+2: the consumer is in S_EX and ex_fwd=01.
- Back-to-back dependent ALU ops: the consumer sees 10 in the cycle after the producer leaves S_EX.

## Configuration
- FWD_WB_BYPASS_EN defined:
  - id_bypass[k] = id_valid & id_src_used[k] & S_WB writing id_src[k].
  - This covers a register file that writes on the edge and reads before write.
  - Combinational from the ID inputs and S_WB.
- FWD_WB_BYPASS_EN undefined:
  - id_bypass is constant 0 and no comparators are built.
  - The register file must be write-first.

## Test plan
- Reset: assert rst_n=0 mid-stream with S_EX holding a load -> stall_id, ex_fwd and stall_cnt read 0 immediately and through 3 cycles after release.
- ALU chain: add r3; then sub using r3 as src0 -> in sub's EX cycle ex_fwd[1:0]=10. With one independent instruction in between -> ex_fwd[1:0]=01.
- Load-use: lw r5, then add r6=r5+r5 -> exactly one cycle with stall_id=1, stall_cnt 0->1, then ex_fwd=4'b0101 for add.
- Double match: r2 written by both S_MEM and S_WB, EX reads r2 -> 10 (youngest wins). Destination r0 with ZERO_REG=1 -> 00 and no stall.
- Hold/flush: hold=1 for 4 cycles during a load-use stall -> stall_cnt unchanged and state frozen, stall_id stays 1, and one stall is counted after release. flush with a load-use match -> stall_id=0 and a bubble enters S_EX.
- FWD_WB_BYPASS_EN: S_WB writes r7, ID reads r7 on src1 -> id_bypass=2'b10. With the macro undefined -> 2'b00.
